// File: rtl/pipeline_skid_reg_if.sv
// pipeline_skid_reg_if: valid/ready handshake bundle carrying a payload and a control field
interface pipeline_skid_reg_if #(
  parameter int DATA_WIDTH = 128,
  parameter int CTRL_WIDTH = 12
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  modport master (output valid, data, ctrl, input ready);
  modport slave (input valid, data, ctrl, output ready);
endinterface

// File: rtl/pipeline_skid_reg.sv
// pipeline_skid_reg: two-entry skid pipeline register with freeze, flush and stall counter
module pipeline_skid_reg #(
  parameter int                    DATA_WIDTH  = 128,
  parameter int                    CTRL_WIDTH  = 12,
  parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0,
  parameter int                    CNT_WIDTH   = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   BUSYWAIT,
  input  logic                   FLUSH,
  pipeline_skid_reg_if.slave     in_if,
  pipeline_skid_reg_if.master    out_if,
  output logic [CNT_WIDTH-1:0]   STALL_CYCLES
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t                state, state_nx;
  logic                  out_valid, in_ready, push, pop;
  logic                  load_in, load_skid, fill_skid, go_bubble;
  logic [DATA_WIDTH-1:0] main_data, skid_data;
  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl;
  logic [CNT_WIDTH-1:0]  cnt;
  // transfer decode and occupancy next-state; flush wins over everything
  always_comb begin
    push      = in_if.valid & in_ready & ~BUSYWAIT & ~FLUSH;
    pop       = out_valid & out_if.ready & ~BUSYWAIT & ~FLUSH;
    state_nx  = FLUSH ? EMPTY : state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    fill_skid = 1'b0;
    go_bubble = FLUSH;
    if (!FLUSH)
      case (state)
        EMPTY: begin
          load_in  = push;
          state_nx = push ? ONE : EMPTY;
        end
        ONE: begin
          load_in   = push & pop;
          fill_skid = push & ~pop;
          go_bubble = pop & ~push;
          state_nx  = push ? (pop ? ONE : TWO) : (pop ? EMPTY : ONE);
        end
        TWO: begin
          load_skid = pop;
          state_nx  = pop ? ONE : TWO;
        end
        default: state_nx = EMPTY;
      endcase
  end
  // occupancy register; handshake flags are registered so they never depend on BUSYWAIT/OUT_READY
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_nx;
      out_valid <= state_nx != EMPTY;
      in_ready  <= state_nx != TWO;
    end
  // payload storage: main drives the outputs, skid absorbs one entry of back-pressure
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      main_data <= '0;
      main_ctrl <= BUBBLE_CTRL;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_in) begin
        main_data <= in_if.data;
        main_ctrl <= in_if.ctrl;
      end else if (load_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end else if (go_bubble)
        main_ctrl <= BUBBLE_CTRL;
      if (fill_skid) begin
        skid_data <= in_if.data;
        skid_ctrl <= in_if.ctrl;
      end
    end
  // saturating count of cycles where a presented entry could not leave
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) cnt <= '0;
    else if (out_valid & (~out_if.ready | BUSYWAIT) & ~&cnt) cnt <= cnt + 1'b1;
  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_data;
  assign out_if.ctrl  = main_ctrl;
  assign STALL_CYCLES = cnt;
endmodule

// File: tb/tb_pipeline_skid_reg.sv
// tb_pipeline_skid_reg: directed scenarios plus randomized traffic against a queue model
module tb_pipeline_skid_reg;
  localparam int              DW = 128;
  localparam int              CW = 12;
  localparam int              NW = 4;
  localparam logic [CW-1:0]   BUB = 12'h5A5;
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  logic          CLK = 1'b0, RESET = 1'b1, busy = 1'b0, flush = 1'b0;
  logic          iv = 1'b0, ordy = 1'b0;
  logic [DW-1:0] idata = '0;
  logic [CW-1:0] ictrl = '0;
  logic [NW-1:0] stall;
  logic          ov, ir;
  logic [DW-1:0] od;
  logic [CW-1:0] oc;
  int            vec = 0, err = 0;
  ent_t          q[$];
  logic [DW-1:0] m_data;
  logic [NW-1:0] m_cnt;
  pipeline_skid_reg_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) u_in ();
  pipeline_skid_reg_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) u_out ();
  assign u_in.valid  = iv;
  assign u_in.data   = idata;
  assign u_in.ctrl   = ictrl;
  assign u_out.ready = ordy;
  assign ov = u_out.valid;
  assign od = u_out.data;
  assign oc = u_out.ctrl;
  assign ir = u_in.ready;
  pipeline_skid_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .BUBBLE_CTRL(BUB), .CNT_WIDTH(NW)) dut (
    .CLK(CLK), .RESET(RESET), .BUSYWAIT(busy), .FLUSH(flush),
    .in_if(u_in), .out_if(u_out), .STALL_CYCLES(stall)
  );
  always #5 CLK = ~CLK;
  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_cnt  = '0;
  endtask
  // one clock: the model applies the transfer rules to the inputs present at the edge
  task automatic tick();
    bit   push, pop;
    ent_t e;
    @(posedge CLK);
    push = iv && q.size() < 2 && !busy && !flush;
    pop  = q.size() > 0 && ordy && !busy && !flush;
    if (q.size() > 0 && (!ordy || busy) && m_cnt != {NW{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.d = idata;
        e.c = ictrl;
        q.push_back(e);
      end
    end
    if (q.size() > 0) m_data = q[0].d;
    #1;
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    model_reset();
    {iv, ordy, busy, flush} = '0;
  endtask
  task automatic push_val(input int v);
    iv    = 1'b1;
    idata = DW'(v);
    ictrl = CW'(v + 12'h100);
  endtask
  task automatic test_reset();
    ordy = 1'b0;
    push_val(8'h17);
    repeat (4) tick();
    #1 RESET = 1'b1;
    #2;
    vec++; if (ov !== 1'b0) begin err++; $display("FAIL reset_valid: got %0b want 0", ov); end
    vec++; if (od !== '0) begin err++; $display("FAIL reset_data: got %0h want 0", od); end
    vec++; if (oc !== BUB) begin err++; $display("FAIL reset_ctrl: got %0h want %0h", oc, BUB); end
    vec++; if (ir !== 1'b1) begin err++; $display("FAIL reset_in_ready: got %0b want 1", ir); end
    vec++; if (stall !== '0) begin err++; $display("FAIL reset_stall: got %0d want 0", stall); end
    #3 RESET = 1'b0;
    #1;
    vec++; if (ov !== 1'b0 || ir !== 1'b1) begin err++; $display("FAIL reset_release: valid %0b ready %0b want 0 1", ov, ir); end
    model_reset();
    iv = 1'b0;
  endtask
  task automatic test_streaming();
    do_reset();
    ordy = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      push_val(10 * i);
      tick();
      vec++; if (ov !== 1'b1 || od !== DW'(10 * i)) begin err++; $display("FAIL stream_out%0d: valid %0b data %0d want 1 %0d", i, ov, od, 10 * i); end
      vec++; if (oc !== CW'(10 * i + 12'h100)) begin err++; $display("FAIL stream_ctrl%0d: got %0h want %0h", i, oc, 10 * i + 12'h100); end
      vec++; if (ir !== 1'b1) begin err++; $display("FAIL stream_ready%0d: got %0b want 1", i, ir); end
    end
    iv = 1'b0;
    tick();
    vec++; if (ov !== 1'b0 || oc !== BUB) begin err++; $display("FAIL stream_drain: valid %0b ctrl %0h want 0 %0h", ov, oc, BUB); end
  endtask
  task automatic test_skid();
    do_reset();
    push_val(10);
    tick();
    vec++; if (od !== DW'(10) || ir !== 1'b1) begin err++; $display("FAIL skid_one: data %0d ready %0b want 10 1", od, ir); end
    push_val(20);
    tick();
    vec++; if (od !== DW'(10) || ir !== 1'b0 || ov !== 1'b1) begin err++; $display("FAIL skid_two: data %0d ready %0b valid %0b want 10 0 1", od, ir, ov); end
    iv   = 1'b0;
    ordy = 1'b1;
    tick();
    vec++; if (od !== DW'(20) || ir !== 1'b1 || ov !== 1'b1) begin err++; $display("FAIL skid_pop: data %0d ready %0b valid %0b want 20 1 1", od, ir, ov); end
    tick();
    vec++; if (ov !== 1'b0) begin err++; $display("FAIL skid_empty: valid %0b want 0", ov); end
  endtask
  task automatic test_busywait();
    do_reset();
    push_val(10);
    tick();
    busy = 1'b1;
    ordy = 1'b1;
    push_val(30);
    for (int i = 1; i <= 3; i++) begin
      tick();
      vec++; if (od !== DW'(10) || ov !== 1'b1 || ir !== 1'b1) begin err++; $display("FAIL busy_hold%0d: data %0d valid %0b ready %0b want 10 1 1", i, od, ov, ir); end
      vec++; if (stall !== NW'(i)) begin err++; $display("FAIL busy_stall%0d: got %0d want %0d", i, stall, i); end
    end
    busy = 1'b0;
    tick();
    vec++; if (od !== DW'(30) || ov !== 1'b1) begin err++; $display("FAIL busy_release: data %0d valid %0b want 30 1", od, ov); end
    iv = 1'b0;
    tick();
    vec++; if (ov !== 1'b0 || stall !== NW'(3)) begin err++; $display("FAIL busy_done: valid %0b stall %0d want 0 3", ov, stall); end
  endtask
  task automatic test_flush();
    do_reset();
    push_val(10);
    tick();
    push_val(20);
    tick();
    flush = 1'b1;
    busy  = 1'b1;
    push_val(99);
    tick();
    vec++; if (ov !== 1'b0 || oc !== BUB || ir !== 1'b1) begin err++; $display("FAIL flush_bubble: valid %0b ctrl %0h ready %0b want 0 %0h 1", ov, oc, ir, BUB); end
    vec++; if (od !== DW'(10)) begin err++; $display("FAIL flush_data_kept: got %0d want 10", od); end
    {flush, busy, iv} = '0;
    ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if (ov !== 1'b0) begin err++; $display("FAIL flush_ghost%0d: valid %0b data %0d want 0", i, ov, od); end
    end
  endtask
  task automatic test_saturation();
    do_reset();
    push_val(5);
    tick();
    iv = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        vec++; if (stall !== NW'(14)) begin err++; $display("FAIL sat_mid: got %0d want 14", stall); end
      end
    end
    vec++; if (stall !== {NW{1'b1}}) begin err++; $display("FAIL sat_final: got %0d want 15", stall); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vec++; if (stall !== {NW{1'b1}}) begin err++; $display("FAIL sat_flush: got %0d want 15", stall); end
  endtask
  task automatic test_random();
    logic [CW-1:0] ec;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      iv    = ($urandom % 3) != 0;
      ordy  = ($urandom % 3) != 0;
      busy  = ($urandom % 8) == 0;
      flush = ($urandom % 25) == 0;
      idata = {$urandom, $urandom, $urandom, $urandom};
      ictrl = CW'($urandom);
      tick();
      ec = q.size() > 0 ? q[0].c : BUB;
      vec++; if (ov !== (q.size() > 0)) begin err++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, ov, q.size() > 0); end
      vec++; if (ir !== (q.size() < 2)) begin err++; $display("FAIL rnd_ready@%0d: got %0b want %0b", i, ir, q.size() < 2); end
      vec++; if (od !== m_data) begin err++; $display("FAIL rnd_data@%0d: got %0h want %0h", i, od, m_data); end
      vec++; if (oc !== ec) begin err++; $display("FAIL rnd_ctrl@%0d: got %0h want %0h", i, oc, ec); end
      vec++; if (stall !== m_cnt) begin err++; $display("FAIL rnd_stall@%0d: got %0d want %0d", i, stall, m_cnt); end
    end
  endtask
  initial begin
    model_reset();
    #3 RESET = 1'b0;
    test_reset();
    test_streaming();
    test_skid();
    test_busywait();
    test_flush();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
